uart_rx_marco: RTL and testbench

//   UART receiver plus command matcher on the "MARCO"/"POLO" path. Samples the rx

---
 rtl/uart_rx_marco.sv | 175 +++++++++++++++++
 tb/tb_uart_rx_marco.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_marco.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_marco
//  Brief    : 8N1 UART receiver (oversampled) with a "MARCO" sequence matcher
//             that requests a "POLO\n" reply without ever dropping one while
//             the downstream transmitter is busy.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_marco #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       os_tick,
    input  logic       rx,
    input  logic       tx_busy,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       send
);

    localparam int c_TICK_W = $clog2(OVERSAMPLE);
    localparam logic [c_TICK_W-1:0] c_HALF_M1 = c_TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_TICK_W-1:0] c_FULL_M1 = c_TICK_W'(OVERSAMPLE - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rx_s;
    logic [1:0]             r_state;
    logic [c_TICK_W-1:0]    r_tick_cnt;
    logic [2:0]             r_bit_cnt;
    logic [7:0]             r_shreg;
    logic [7:0]             r_rx_data;
    logic                   r_rx_valid;
    logic                   r_frame_err;
    logic [2:0]             r_match_idx;
    logic [7:0]             w_exp_byte;
    logic                   w_byte_hit;
    logic                   w_match_done;
    logic                   r_pending;
    logic                   r_send;

    // Metastability synchronizer; resets to the idle-high line level
    always_ff @(posedge clk) begin
        if (rst) r_sync <= '1;
        else     r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
    end

    assign w_rx_s = r_sync[SYNC_STAGES-1];

    // Receive FSM: start-bit qualification, mid-bit data sampling, stop check
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_tick_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shreg     <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (!w_rx_s) begin
                        r_state    <= c_START;
                        r_tick_cnt <= '0;
                    end
                end
                c_START: begin
                    if (os_tick) begin
                        if (r_tick_cnt == c_HALF_M1) begin
                            // A line that is high again at mid start bit was a glitch
                            r_state    <= w_rx_s ? c_IDLE : c_DATA;
                            r_tick_cnt <= '0;
                            r_bit_cnt  <= '0;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                c_DATA: begin
                    if (os_tick) begin
                        if (r_tick_cnt == c_FULL_M1) begin
                            r_tick_cnt <= '0;
                            r_shreg    <= {w_rx_s, r_shreg[7:1]};
                            if (r_bit_cnt == 3'd7) r_state <= c_STOP;
                            else                   r_bit_cnt <= r_bit_cnt + 1'b1;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                default: begin // c_STOP
                    if (os_tick) begin
                        if (r_tick_cnt == c_FULL_M1) begin
                            r_tick_cnt <= '0;
                            // Leave at mid stop bit so a back-to-back start is caught
                            r_state    <= c_IDLE;
                            if (w_rx_s) begin
                                r_rx_data  <= r_shreg;
                                r_rx_valid <= 1'b1;
                            end else begin
                                r_frame_err <= 1'b1;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Next byte expected in the "MARCO" sequence
    always_comb begin
        w_exp_byte = 8'h4D;
        case (r_match_idx)
            3'd0:    w_exp_byte = 8'h4D; // M
            3'd1:    w_exp_byte = 8'h41; // A
            3'd2:    w_exp_byte = 8'h52; // R
            3'd3:    w_exp_byte = 8'h43; // C
            3'd4:    w_exp_byte = 8'h4F; // O
            default: w_exp_byte = 8'h4D;
        endcase
    end

    assign w_byte_hit   = r_rx_valid && (r_rx_data == w_exp_byte);
    assign w_match_done = w_byte_hit && (r_match_idx == 3'd4);

    // Sequence tracker; a stray 'M' restarts the match at index 1
    always_ff @(posedge clk) begin
        if (rst) begin
            r_match_idx <= '0;
        end else if (r_frame_err) begin
            r_match_idx <= '0;
        end else if (r_rx_valid) begin
            if (w_byte_hit)                r_match_idx <= w_match_done ? 3'd0 : r_match_idx + 1'b1;
            else if (r_rx_data == 8'h4D)   r_match_idx <= 3'd1;
            else                           r_match_idx <= 3'd0;
        end
    end

    // Reply request: fire when the transmitter is free, else hold one pending
    always_ff @(posedge clk) begin
        if (rst) begin
            r_send    <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_send <= 1'b0;
            if (w_match_done || r_pending) begin
                if (!tx_busy && !r_send) begin
                    r_send    <= 1'b1;
                    r_pending <= 1'b0;
                end else begin
                    r_pending <= 1'b1;
                end
            end
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign send      = r_send;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_marco.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_marco
//  Brief    : Scoreboard bench for uart_rx_marco; directed byte streams with
//             hand-listed expected rx_valid / frame_err / send events.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_marco;

    localparam logic [1:0] c_K_VALID = 2'd0;
    localparam logic [1:0] c_K_FERR  = 2'd1;
    localparam logic [1:0] c_K_SEND  = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
        logic       lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       os_tick;
    logic       rx = 1'b1;
    logic       tx_busy = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       send;

    logic [1:0] r_tdiv = 2'd0;
    int         cyc = 0;
    int         rel_cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    logic       prev_send = 1'b0;
    exp_t       q[$];

    uart_rx_marco #(.OVERSAMPLE(16), .SYNC_STAGES(2)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .os_tick   (os_tick),
        .rx        (rx),
        .tx_busy   (tx_busy),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .send      (send)
    );

    always #5 clk = ~clk;

    // os_tick: one clk in four, changed on the falling edge
    always @(negedge clk) r_tdiv <= r_tdiv + 2'd1;
    assign os_tick = (r_tdiv == 2'd3);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input int act, input int req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic expect_evt(input logic [1:0] kind, input logic [7:0] data, input logic lat);
        exp_t e;
        e.kind = kind;
        e.data = data;
        e.lat  = lat;
        q.push_back(e);
    endtask

    // Pop one expectation and compare it against an observed DUT event
    task automatic observe(input logic [1:0] kind, input logic [7:0] data);
        exp_t e;
        if (q.size() == 0) begin
            chk(1'b0, "unexpected_event", int'(kind), 3);
        end else begin
            e = q.pop_front();
            chk(e.kind == kind, "event_kind", int'(kind), int'(e.kind));
            if (kind == c_K_VALID && e.kind == c_K_VALID)
                chk(data == e.data, "rx_data", int'(data), int'(e.data));
            if (kind == c_K_SEND && e.lat)
                chk(cyc == rel_cyc + 1, "send_after_release", cyc - rel_cyc, 1);
        end
    endtask

    // Monitor: sample outputs on the falling edge
    always @(negedge clk) begin
        if (rx_valid === 1'b1)  observe(c_K_VALID, rx_data);
        if (frame_err === 1'b1) observe(c_K_FERR, 8'h00);
        if (send === 1'b1) begin
            observe(c_K_SEND, 8'h00);
            chk(prev_send !== 1'b1, "send_back_to_back", 1, 0);
        end
        prev_send <= send;
    end

    task automatic drive_bit(input logic b, input int n);
        rx = b;
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (os_tick !== 1'b1);
            #1;
        end
    endtask

    // One 8N1 frame plus two idle bits; expectations are queued up front
    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit exp_send);
        if (stop_ok) expect_evt(c_K_VALID, b, 1'b0);
        else         expect_evt(c_K_FERR, 8'h00, 1'b0);
        if (exp_send) expect_evt(c_K_SEND, 8'h00, 1'b0);
        drive_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) drive_bit(b[i], 16);
        if (stop_ok) begin
            drive_bit(1'b1, 16);
        end else begin
            drive_bit(1'b0, 10);
            drive_bit(1'b1, 6);
        end
        drive_bit(1'b1, 32);
    endtask

    // send_mask bit i set: a send is expected right after character i
    task automatic send_seq(input string s, input int send_mask);
        for (int i = 0; i < s.len(); i++)
            send_byte(s[i], 1'b1, send_mask[i]);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        repeat (20) @(posedge clk);
        chk(q.size() == 0, name, q.size(), 0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk(rx_data == 8'h00, "reset_rx_data", int'(rx_data), 0);
        chk(rx_valid == 1'b0, "reset_rx_valid", int'(rx_valid), 0);
        chk(frame_err == 1'b0, "reset_frame_err", int'(frame_err), 0);
        chk(send == 1'b0, "reset_send", int'(send), 0);
        rst = 1'b0;
        drive_bit(1'b1, 32);

        // Single byte, no send
        send_byte(8'h41, 1'b1, 1'b0);
        wait_drain("drain_single");

        // Plain match
        send_seq("MARCO", 1 << 4);
        wait_drain("drain_marco");

        // Repeated M, broken sequence, back-to-back matches
        send_seq("MMARCO", 1 << 5);
        send_seq("MARXO", 0);
        send_seq("MARCOMARCO", (1 << 4) | (1 << 9));
        wait_drain("drain_variants");

        // Short low glitch, then a normal byte proves the receiver is idle again
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 32);
        send_byte(8'h5A, 1'b1, 1'b0);
        wait_drain("drain_glitch");

        // Framing error in the middle of the sequence breaks the match
        send_seq("MAR", 0);
        send_byte(8'h43, 1'b0, 1'b0);
        send_seq("CO", 0);
        wait_drain("drain_ferr");
        chk(rx_data == 8'h4F, "rx_data_after_ferr_seq", int'(rx_data), 8'h4F);

        // Framing error alone leaves rx_data holding the last good byte
        send_byte(8'h33, 1'b1, 1'b0);
        send_byte(8'h77, 1'b0, 1'b0);
        wait_drain("drain_ferr_hold");
        chk(rx_data == 8'h33, "rx_data_held", int'(rx_data), 8'h33);

        // Busy transmitter: reply waits and fires once on release
        @(negedge clk) tx_busy = 1'b1;
        send_seq("MARCO", 0);
        expect_evt(c_K_SEND, 8'h00, 1'b1);
        repeat (100) @(posedge clk);
        @(negedge clk);
        tx_busy = 1'b0;
        rel_cyc = cyc;
        wait_drain("drain_busy");

        // Reset mid-byte discards the partial frame
        send_seq("MA", 0);
        drive_bit(1'b0, 16);
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 16);
        drive_bit(1'b0, 8);
        @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        chk(rx_data == 8'h00, "midrst_rx_data", int'(rx_data), 0);
        chk(rx_valid == 1'b0, "midrst_rx_valid", int'(rx_valid), 0);
        chk(frame_err == 1'b0, "midrst_frame_err", int'(frame_err), 0);
        chk(send == 1'b0, "midrst_send", int'(send), 0);
        @(negedge clk);
        rst = 1'b0;
        drive_bit(1'b1, 32);
        send_seq("MARCO", 1 << 4);
        wait_drain("drain_after_reset");

        chk(q.size() == 0, "final_queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
